dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 12 +
 rtl/rr_arb2.sv | 46 ++++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory arbiter.
// No logic; FSM state encoding and default geometry only.
// Imported by dmem_arbiter and rr_arb2.
package dmem_pkg;
    localparam int DATA_W     = 32;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant with lock-based hold, capped at MAX_HOLD consecutive grants.
// Latency: gnt is combinational from req/lock; ownership and hold count update on take.
// Backpressure: none; the caller pulses take only when it accepts the grant.
module rr_arb2 import dmem_pkg::*; #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic       take,
    output logic       gnt
);
    localparam int             CW       = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LIM = CW'(MAX_HOLD - 1);

    logic          last;
    logic [CW-1:0] hold_cnt;
    logic          retain;

    // hold_cnt counts grants kept beyond the first one of the current ownership run
    always_comb begin
        retain = req[last] && lock[last] && (hold_cnt < HOLD_LIM);
        gnt    = last;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = retain ? last : ~last;
            default: gnt = last;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last     <= 1'b1;
            hold_cnt <= '0;
        end else if (take) begin
            last <= gnt;
            if (gnt == last && lock[gnt]) begin
                if (hold_cnt < HOLD_LIM) hold_cnt <= hold_cnt + CW'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory with range checking.
// Latency: req sampled in cycle N -> ack/err/rdata in cycle N+2; one access per two cycles.
// Backpressure: requester holds req and operands until ack; losers simply wait.
module dmem_arbiter import dmem_pkg::*; #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [DATA_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [DATA_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    state_t            state, state_nxt;
    logic              gnt_q, we_q, arb_gnt, take, in_range;
    logic [DATA_W-1:0] addr_q, wdata_q, rsp_data;

    assign take     = (state == IDLE) && (p0_req || p1_req);
    assign in_range = (addr_q >> ADDR_W) == '0;
    assign rsp_data = (we_q || !in_range) ? '0 : mem_data_out;

    rr_arb2 #(.MAX_HOLD(MAX_HOLD)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({p1_req, p0_req}),
        .lock  ({p1_lock, p0_lock}),
        .take  (take),
        .gnt   (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // rst_n gates the write strobe so an ACCESS cut short by reset never commits
    always_comb begin
        state_nxt   = state;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        case (state)
            IDLE: if (take) state_nxt = ACCESS;
            ACCESS: begin
                state_nxt   = IDLE;
                mem_addr    = addr_q;
                mem_data_in = wdata_q;
                mem_wr_en   = we_q && in_range && rst_n;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            p0_ack   <= 1'b0;
            p0_err   <= 1'b0;
            p0_rdata <= '0;
            p1_ack   <= 1'b0;
            p1_err   <= 1'b0;
            p1_rdata <= '0;
        end else begin
            p0_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_ack <= 1'b0;
            p1_err <= 1'b0;
            if (take) begin
                gnt_q   <= arb_gnt;
                we_q    <= arb_gnt ? p1_we    : p0_we;
                addr_q  <= arb_gnt ? p1_addr  : p0_addr;
                wdata_q <= arb_gnt ? p1_wdata : p0_wdata;
            end
            if (state == ACCESS) begin
                if (gnt_q) begin
                    p1_ack   <= 1'b1;
                    p1_err   <= !in_range;
                    p1_rdata <= rsp_data;
                end else begin
                    p0_ack   <= 1'b1;
                    p0_err   <= !in_range;
                    p0_rdata <= rsp_data;
                end
            end
        end
    end
endmodule
